// File: rtl/mips_hazard_pkg.sv
// Shared MIPS hazard-control definitions.
// Holds the opcode/funct encodings the stall controller decodes and the
// stall_cause enumeration reported on its status port.
package mips_hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  // Width of the control-stall countdown register.
  localparam int CD_W = 4;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_CTRL = 2'b01,
    CAUSE_LU   = 2'b10,
    CAUSE_EXT  = 2'b11
  } stall_cause_e;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Bundle between the IF/ID stage logic and the stall controller.
// master : pipeline side, drives the ID/EX observations and external hold.
// slave  : stall controller, returns stall/flush requests and status.
//   id_instr, id_valid      instruction in ID and its validity
//   ex_mem_read, ex_rt      load in EX and its destination register
//   ext_hold                external freeze request
//   stall, flush_ex         freeze PC+IF/ID, bubble into ID/EX
//   stall_cause, busy       status: dominant cause, control countdown active
//   stall_count             saturating count of stalled cycles
interface pipeline_stall_ctrl_if
  import mips_hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) ();

  logic [31:0]      id_instr;
  logic             id_valid;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rt;
  logic             ext_hold;
  logic             stall;
  logic             flush_ex;
  stall_cause_e     stall_cause;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_instr, id_valid, ex_mem_read, ex_rt, ext_hold,
    input  stall, flush_ex, stall_cause, busy, stall_count
  );

  modport slave (
    input  id_instr, id_valid, ex_mem_read, ex_rt, ext_hold,
    output stall, flush_ex, stall_cause, busy, stall_count
  );

endinterface

// File: rtl/pipeline_stall_ctrl_decode.sv
// instr_hazard_decode: purely combinational classification of the ID
// instruction for hazard purposes.
//   instr     in  32     instruction word
//   is_branch out 1      BEQ / BNE
//   is_jump   out 1      J / JAL / JR / JALR
//   rs, rt    out REG_W  source register fields
//   reads_rt  out 1      instruction actually consumes rt as a source
module instr_hazard_decode
  import mips_hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [31:0]      instr,
  output logic             is_branch,
  output logic             is_jump,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic             reads_rt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype;
  logic       is_jr_class;

  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign rs          = REG_W'(instr[25:21]);
  assign rt          = REG_W'(instr[20:16]);

  assign is_rtype    = (opcode == OP_RTYPE);
  // JR/JALR are R-type encodings but only read rs.
  assign is_jr_class = is_rtype && ((funct == FN_JR) || (funct == FN_JALR));

  assign is_branch   = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_jump     = (opcode == OP_J) || (opcode == OP_JAL) || is_jr_class;

  // Stores read rt as the data operand; I-type ALU ops and loads write it.
  assign reads_rt    = (is_rtype && !is_jr_class) || is_branch || (opcode == OP_SW);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: control-hazard and load-use stall controller sitting
// beside the IF/ID register.
//   clk   in   pipeline clock, rising edge
//   rst   in   synchronous active-high reset (clears countdown and counter)
//   bus   slave modport of pipeline_stall_ctrl_if (see interface header)
// A branch/jump in ID loads a countdown with CTRL_STALL_CYCLES; stall is held
// while it is nonzero. A load in EX feeding the ID instruction stalls in the
// same cycle and, when it is the only reason to stall, bubbles ID/EX.
// ext_hold freezes the countdown and forces stall.
module pipeline_stall_ctrl
  import mips_hazard_pkg::*;
#(
  parameter int CTRL_STALL_CYCLES = 1,
  parameter int LU_ENABLE         = 1,
  parameter int REG_W             = 5,
  parameter int CNT_W             = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_stall_ctrl_if.slave bus
);

  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(CTRL_STALL_CYCLES);
  localparam logic            LU_EN   = (LU_ENABLE != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             is_branch;
  logic             is_jump;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic             reads_rt;

  logic [CD_W-1:0]  countdown_p1;
  logic [CD_W-1:0]  countdown_nxt;
  logic [CNT_W-1:0] stall_cnt_p1;

  logic busy;
  logic lu_match;
  logic lu_stall;
  logic ctrl_hit;
  logic stall;

  instr_hazard_decode #(
    .REG_W (REG_W)
  ) u_decode (
    .instr     (bus.id_instr),
    .is_branch (is_branch),
    .is_jump   (is_jump),
    .rs        (rs),
    .rt        (rt),
    .reads_rt  (reads_rt)
  );

  // ---- stage 0: combinational hazard detection ----
  assign busy     = (countdown_p1 != '0);
  assign lu_match = (bus.ex_rt == rs) || (reads_rt && (bus.ex_rt == rt));
  assign lu_stall = LU_EN && bus.id_valid && bus.ex_mem_read &&
                    (bus.ex_rt != '0) && lu_match;

  // A branch that also has a load-use dependency, or sits under an external
  // hold, waits in ID; its countdown starts once both have cleared.
  assign ctrl_hit = bus.id_valid && (is_branch || is_jump) && !busy &&
                    !lu_stall && !bus.ext_hold;

  assign stall    = busy || lu_stall || bus.ext_hold;

  always_comb begin
    countdown_nxt = countdown_p1;
    if (ctrl_hit) begin
      countdown_nxt = CD_LOAD;
    end else if (busy && !bus.ext_hold) begin
      countdown_nxt = countdown_p1 - 1'b1;
    end
  end

  // ---- stage 1: countdown and stall-cycle counter registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      countdown_p1 <= '0;
      stall_cnt_p1 <= '0;
    end else begin
      countdown_p1 <= countdown_nxt;
      if (stall) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
    end
  end

  // ---- outputs ----
  always_comb begin
    bus.stall_cause = CAUSE_NONE;
    if (bus.ext_hold)  bus.stall_cause = CAUSE_EXT;
    else if (busy)     bus.stall_cause = CAUSE_CTRL;
    else if (lu_stall) bus.stall_cause = CAUSE_LU;
  end

  assign bus.stall       = stall;
  assign bus.flush_ex    = lu_stall && !busy && !bus.ext_hold;
  assign bus.busy        = busy;
  assign bus.stall_count = stall_cnt_p1;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: one instance with a 1-cycle control
// stall, one with 3 cycles, and one with a 2-bit counter for saturation.
module tb_pipeline_stall_ctrl;
  import mips_hazard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) b1 ();
  pipeline_stall_ctrl_if #(.REG_W(5), .CNT_W(16)) b3 ();
  pipeline_stall_ctrl_if #(.REG_W(5), .CNT_W(2))  bs ();

  pipeline_stall_ctrl #(
    .CTRL_STALL_CYCLES(1), .LU_ENABLE(1), .REG_W(5), .CNT_W(16)
  ) dut1 (.clk(clk), .rst(rst), .bus(b1));

  pipeline_stall_ctrl #(
    .CTRL_STALL_CYCLES(3), .LU_ENABLE(1), .REG_W(5), .CNT_W(16)
  ) dut3 (.clk(clk), .rst(rst), .bus(b3));

  pipeline_stall_ctrl #(
    .CTRL_STALL_CYCLES(1), .LU_ENABLE(1), .REG_W(5), .CNT_W(2)
  ) duts (.clk(clk), .rst(rst), .bus(bs));

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b1.id_instr = '0; b1.id_valid = 1'b0; b1.ex_mem_read = 1'b0; b1.ex_rt = '0; b1.ext_hold = 1'b0;
    b3.id_instr = '0; b3.id_valid = 1'b0; b3.ex_mem_read = 1'b0; b3.ex_rt = '0; b3.ext_hold = 1'b0;
    bs.id_instr = '0; bs.id_valid = 1'b0; bs.ex_mem_read = 1'b0; bs.ex_rt = '0; bs.ext_hold = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  initial begin
    idle_all();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_stall",  32'(b1.stall), 32'd0);
    check("rst_busy",   32'(b1.busy), 32'd0);
    check("rst_flush",  32'(b1.flush_ex), 32'd0);
    check("rst_cause",  32'(b1.stall_cause), 32'(CAUSE_NONE));
    check("rst_count1", 32'(b1.stall_count), 32'd0);
    check("rst_count3", 32'(b3.stall_count), 32'd0);

    // N=1: BEQ stalls exactly one cycle
    b1.id_instr = enc_i(OP_BEQ, 5'd1, 5'd2, 16'd4);
    b1.id_valid = 1'b1;
    #1;
    check("beq_t_stall", 32'(b1.stall), 32'd0);
    cyc();
    check("beq_t1_stall", 32'(b1.stall), 32'd1);
    check("beq_t1_cause", 32'(b1.stall_cause), 32'(CAUSE_CTRL));
    check("beq_t1_busy",  32'(b1.busy), 32'd1);
    check("beq_t1_flush", 32'(b1.flush_ex), 32'd0);
    cyc();
    check("beq_t2_stall", 32'(b1.stall), 32'd0);
    check("beq_t2_busy",  32'(b1.busy), 32'd0);
    check("beq_t2_count", 32'(b1.stall_count), 32'd1);
    b1.id_instr = enc_r(5'd3, 5'd4, 5'd5, FN_ADD);
    cyc();
    check("beq_t3_stall", 32'(b1.stall), 32'd0);
    check("beq_t3_count", 32'(b1.stall_count), 32'd1);

    // N=3: J with ext_hold over two cycles of the countdown -> 5 stall cycles
    do_reset();
    b3.id_instr = {OP_J, 26'd100};
    b3.id_valid = 1'b1;
    #1;
    check("j_t_stall", 32'(b3.stall), 32'd0);
    cyc();
    check("j_t1_stall", 32'(b3.stall), 32'd1);
    check("j_t1_busy",  32'(b3.busy), 32'd1);
    b3.id_valid = 1'b0;
    cyc();
    b3.ext_hold = 1'b1;
    #1;
    check("j_t2_cause", 32'(b3.stall_cause), 32'(CAUSE_EXT));
    check("j_t2_stall", 32'(b3.stall), 32'd1);
    cyc();
    check("j_t3_cause", 32'(b3.stall_cause), 32'(CAUSE_EXT));
    check("j_t3_busy",  32'(b3.busy), 32'd1);
    cyc();
    b3.ext_hold = 1'b0;
    #1;
    check("j_t4_stall", 32'(b3.stall), 32'd1);
    check("j_t4_cause", 32'(b3.stall_cause), 32'(CAUSE_CTRL));
    cyc();
    check("j_t5_stall", 32'(b3.stall), 32'd1);
    check("j_t5_busy",  32'(b3.busy), 32'd1);
    cyc();
    check("j_t6_stall", 32'(b3.stall), 32'd0);
    check("j_t6_busy",  32'(b3.busy), 32'd0);
    check("j_t6_count", 32'(b3.stall_count), 32'd5);

    // Load-use detection (combinational, N=1 instance)
    do_reset();
    b1.ex_mem_read = 1'b1;
    b1.ex_rt       = 5'd8;
    b1.id_instr    = enc_r(5'd8, 5'd10, 5'd9, FN_ADD);
    b1.id_valid    = 1'b1;
    #1;
    check("lu_rs_stall", 32'(b1.stall), 32'd1);
    check("lu_rs_flush", 32'(b1.flush_ex), 32'd1);
    check("lu_rs_cause", 32'(b1.stall_cause), 32'(CAUSE_LU));
    b1.ex_rt = 5'd0;
    #1;
    check("lu_r0_stall", 32'(b1.stall), 32'd0);
    check("lu_r0_flush", 32'(b1.flush_ex), 32'd0);
    b1.ex_rt = 5'd10;
    #1;
    check("lu_rt_rtype", 32'(b1.stall), 32'd1);
    b1.ex_rt    = 5'd9;
    b1.id_instr = enc_i(OP_ADDI, 5'd8, 5'd9, 16'd5);
    #1;
    check("lu_addi_stall", 32'(b1.stall), 32'd0);
    b1.id_instr = enc_i(OP_SW, 5'd8, 5'd9, 16'd0);
    #1;
    check("lu_sw_stall", 32'(b1.stall), 32'd1);
    check("lu_sw_flush", 32'(b1.flush_ex), 32'd1);
    b1.id_valid = 1'b0;
    #1;
    check("lu_invalid_stall", 32'(b1.stall), 32'd0);
    b1.ex_mem_read = 1'b0;

    // BEQ after lw (N=3): 1 load-use cycle, 1 detect cycle, 3 control cycles
    do_reset();
    b3.ex_mem_read = 1'b1;
    b3.ex_rt       = 5'd8;
    b3.id_instr    = enc_i(OP_BEQ, 5'd8, 5'd1, 16'd2);
    b3.id_valid    = 1'b1;
    #1;
    check("bl_a_stall", 32'(b3.stall), 32'd1);
    check("bl_a_flush", 32'(b3.flush_ex), 32'd1);
    check("bl_a_busy",  32'(b3.busy), 32'd0);
    cyc();
    b3.ex_mem_read = 1'b0;
    #1;
    check("bl_b_stall", 32'(b3.stall), 32'd0);
    cyc();
    b3.id_instr    = enc_r(5'd8, 5'd2, 5'd3, FN_ADD);
    b3.ex_mem_read = 1'b1;
    #1;
    check("bl_c_stall", 32'(b3.stall), 32'd1);
    check("bl_c_flush", 32'(b3.flush_ex), 32'd0);
    check("bl_c_cause", 32'(b3.stall_cause), 32'(CAUSE_CTRL));
    cyc();
    b3.ex_mem_read = 1'b0;
    b3.id_valid    = 1'b0;
    #1;
    check("bl_d_stall", 32'(b3.stall), 32'd1);
    cyc();
    check("bl_e_stall", 32'(b3.stall), 32'd1);
    cyc();
    check("bl_f_stall", 32'(b3.stall), 32'd0);
    check("bl_f_busy",  32'(b3.busy), 32'd0);
    check("bl_f_count", 32'(b3.stall_count), 32'd4);

    // Reset in the middle of a 3-cycle countdown
    do_reset();
    b3.id_instr = {OP_J, 26'd7};
    b3.id_valid = 1'b1;
    cyc();
    b3.id_valid = 1'b0;
    cyc();
    check("mid_busy", 32'(b3.busy), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 32'(b3.stall), 32'd0);
    check("mid_rst_busy",  32'(b3.busy), 32'd0);
    check("mid_rst_count", 32'(b3.stall_count), 32'd0);
    b3.id_instr = enc_r(5'd31, 5'd0, 5'd0, FN_JR);
    #1;
    check("jr_inv_stall", 32'(b3.stall), 32'd0);
    cyc();
    check("jr_inv_busy", 32'(b3.busy), 32'd0);
    b3.id_valid = 1'b1;
    cyc();
    b3.id_valid = 1'b0;
    #1;
    check("jr_val_busy",  32'(b3.busy), 32'd1);
    check("jr_val_cause", 32'(b3.stall_cause), 32'(CAUSE_CTRL));

    // Saturation of a 2-bit counter
    bs.ext_hold = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    check("sat_count", 32'(bs.stall_count), 32'd3);
    cyc();
    check("sat_hold", 32'(bs.stall_count), 32'd3);
    bs.ext_hold = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
